// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the parametrised single-clock FIFO, plus a ceil-log2 helper
// used to size the occupancy counter (needs to represent 0..DEPTH inclusive).
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_ADDR_WIDTH    = 3;
    localparam int DEF_AFULL_THRESH  = 6;
    localparam int DEF_AEMPTY_THRESH = 2;

    function automatic int fifo_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: 2**ADDR_WIDTH x DATA_WIDTH, synchronous write, read port either
// registered (REG_RD=1, updates only on i_re) or asynchronous (REG_RD=0). No reset.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit REG_RD     = 1'b1
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    generate
        if (REG_RD) begin : g_reg_rd
            logic [DATA_WIDTH-1:0] r_q;

            always_ff @(posedge clk) begin
                if (i_re) begin
                    r_q <= r_mem[i_raddr];
                end
            end

            assign o_rdata = r_q;
        end else begin : g_async_rd
            // Read enable has no meaning for a combinational port.
            logic w_unused_re;
            assign w_unused_re = i_re;
            assign o_rdata     = r_mem[i_raddr];
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with count, almost flags and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int AFULL_THRESH  = DEF_AFULL_THRESH,
    parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH,
    localparam int DEPTH        = 1 << ADDR_WIDTH,
    localparam int CNT_W        = fifo_clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      AFULL_C  = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0]      AEMPTY_C = CNT_W'(AEMPTY_THRESH);
    localparam logic [CNT_W-1:0]      CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   PTR_ONE  = 1;

    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_count_nxt;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [DATA_WIDTH-1:0] w_ram_q;

    // Flags come only from the registered count, never from this cycle's requests.
    assign w_full       = (r_count == DEPTH_C);
    assign w_empty      = (r_count == '0);
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= AFULL_C);
    assign almost_empty = (r_count <= AEMPTY_C);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    assign w_wr_acc = wr_en & ~w_full;
    assign w_rd_acc = rd_en & ~w_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count     <= w_count_nxt;
            r_overflow  <= wr_en & w_full;
            r_underflow <= rd_en & w_empty;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_RD     (1'b0)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wdata (wr_data),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rdata (w_ram_q)
    );

    // Head word is always on display; rd_en just acknowledges it.
    assign rd_data  = w_ram_q;
    assign rd_valid = ~w_empty;
`else
    logic r_rd_valid;
    logic r_rd_seen;

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_RD     (1'b1)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wdata (wr_data),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_seen  <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_seen <= 1'b1;
            end
        end
    end

    // The RAM output register has no reset, so rd_data reads as zero until the first pop.
    assign rd_data  = r_rd_seen ? w_ram_q : '0;
    assign rd_valid = r_rd_valid;
`endif

endmodule
